// File: rtl/pipeline_sequencer.sv
// Per-sample scheduler: input gain, pipeline tick/wait with timeout, linear crossfade, output gain.
// Optional build macro SEQ_OVERRUN_COUNT_EN enables the dropped-sample counter on overrun_count.
module pipeline_sequencer #(
   parameter int data_width     = 16,
   parameter int n_pipelines    = 2,
   parameter int gain_shift     = 5,
   parameter int fade_len_log2  = 8,
   parameter int timeout_cycles = 1023,
   localparam int sel_width     = (n_pipelines > 1) ? $clog2(n_pipelines) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic signed [data_width-1:0]        in_sample,
   input  logic                                sample_valid,
   output logic                                ready,
   output logic signed [data_width-1:0]        out_sample,
   output logic                                out_valid,
   output logic signed [data_width-1:0]        pipe_in_sample,
   output logic                                pipeline_tick,
   input  logic [n_pipelines-1:0]              pipe_ready,
   input  logic [n_pipelines*data_width-1:0]   pipe_out,
   input  logic signed [data_width-1:0]        gain_data,
   input  logic                                set_input_gain,
   input  logic                                set_output_gain,
   input  logic [sel_width-1:0]                swap_target,
   input  logic                                swap_req,
   output logic                                swapping,
   output logic [sel_width-1:0]                current_pipeline,
   output logic                                timeout_error,
   output logic [15:0]                         overrun_count
);

   localparam int prod_width = 2 * data_width;
   localparam int mix_width  = data_width + fade_len_log2 + 1;
   localparam int cnt_width  = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;

   localparam logic signed [data_width-1:0] unity_gain = data_width'(1 << gain_shift);
   localparam logic [fade_len_log2:0]       fade_full  = {1'b1, {fade_len_log2{1'b0}}};
   localparam logic [fade_len_log2:0]       fade_last  = fade_full - 1'b1;
   localparam logic [cnt_width-1:0]         timeout_last = cnt_width'(timeout_cycles - 1);

   localparam logic signed [prod_width-1:0] sat_max =
      {{(data_width + 1){1'b0}}, {(data_width - 1){1'b1}}};
   localparam logic signed [prod_width-1:0] sat_min =
      {{(data_width + 1){1'b1}}, {(data_width - 1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_IN_GAIN  = 3'd1,
      S_SETTLE   = 3'd2,
      S_WAIT     = 3'd3,
      S_MIX      = 3'd4,
      S_OUT_GAIN = 3'd5
   } state_t;

   state_t                       state;
   logic signed [data_width-1:0] sample_reg;
   logic signed [data_width-1:0] gain_in;
   logic signed [data_width-1:0] gain_out;
   logic signed [data_width-1:0] mixed;
   logic [fade_len_log2:0]       fade_k;
   logic [sel_width-1:0]         swap_tgt;
   logic [cnt_width-1:0]         wait_cnt;

   logic signed [data_width-1:0] cur_word;
   logic signed [data_width-1:0] tgt_word;
   logic                         cur_rdy;
   logic                         tgt_rdy;
   logic                         all_rdy;
   logic                         swap_accept;

   logic signed [prod_width-1:0] in_prod;
   logic signed [prod_width-1:0] out_prod;
   logic signed [mix_width-1:0]  cur_ext;
   logic signed [mix_width-1:0]  tgt_ext;
   logic signed [mix_width-1:0]  cur_weight;
   logic signed [mix_width-1:0]  tgt_weight;
   logic signed [mix_width-1:0]  mix_sum;
   logic signed [data_width-1:0] mix_word;

   function automatic logic signed [data_width-1:0] saturate(
      input logic signed [prod_width-1:0] value
   );
      if (value > sat_max) begin
         return {1'b0, {(data_width - 1){1'b1}}};
      end else if (value < sat_min) begin
         return {1'b1, {(data_width - 1){1'b0}}};
      end else begin
         return value[data_width-1:0];
      end
   endfunction

   // Select the active and fade-target pipeline words and done flags.
   always_comb begin
      cur_word = '0;
      tgt_word = '0;
      cur_rdy  = 1'b0;
      tgt_rdy  = 1'b0;
      for (int i = 0; i < n_pipelines; i++) begin
         if (sel_width'(i) == current_pipeline) begin
            cur_word = pipe_out[i*data_width +: data_width];
            cur_rdy  = pipe_ready[i];
         end
         if (sel_width'(i) == swap_tgt) begin
            tgt_word = pipe_out[i*data_width +: data_width];
            tgt_rdy  = pipe_ready[i];
         end
      end
   end

   assign all_rdy = cur_rdy && (!swapping || tgt_rdy);

   assign swap_accept = swap_req && !swapping &&
                        (swap_target != current_pipeline) &&
                        (int'(swap_target) < n_pipelines);

   assign in_prod  = prod_width'(sample_reg) * prod_width'(gain_in);
   assign out_prod = prod_width'(mixed) * prod_width'(gain_out);

   // Weights are non-negative and sum to 2^L, so the blend cannot overflow data_width.
   assign cur_ext    = mix_width'(cur_word);
   assign tgt_ext    = mix_width'(tgt_word);
   assign cur_weight = $signed(mix_width'(fade_full - fade_k));
   assign tgt_weight = $signed(mix_width'(fade_k));
   assign mix_sum    = cur_ext * cur_weight + tgt_ext * tgt_weight;
   assign mix_word   = data_width'(mix_sum >>> fade_len_log2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= S_IDLE;
         ready            <= 1'b1;
         out_sample       <= '0;
         out_valid        <= 1'b0;
         pipe_in_sample   <= '0;
         pipeline_tick    <= 1'b0;
         swapping         <= 1'b0;
         current_pipeline <= '0;
         timeout_error    <= 1'b0;
         sample_reg       <= '0;
         gain_in          <= unity_gain;
         gain_out         <= unity_gain;
         mixed            <= '0;
         fade_k           <= '0;
         swap_tgt         <= '0;
         wait_cnt         <= '0;
      end else begin
         pipeline_tick <= 1'b0;
         out_valid     <= 1'b0;

         if (set_input_gain) begin
            gain_in <= gain_data;
         end
         if (set_output_gain) begin
            gain_out <= gain_data;
         end

         if (swap_accept) begin
            swapping <= 1'b1;
            swap_tgt <= swap_target;
         end

         case (state)
            S_IDLE: begin
               if (sample_valid) begin
                  sample_reg <= in_sample;
                  ready      <= 1'b0;
                  state      <= S_IN_GAIN;
               end
            end
            S_IN_GAIN: begin
               pipe_in_sample <= saturate(in_prod >>> gain_shift);
               pipeline_tick  <= 1'b1;
               state          <= S_SETTLE;
            end
            S_SETTLE: begin
               // The settle cycle counts toward the timeout budget.
               wait_cnt <= cnt_width'(1);
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (all_rdy) begin
                  state <= S_MIX;
               end else if (wait_cnt >= timeout_last) begin
                  timeout_error <= 1'b1;
                  state         <= S_MIX;
               end else begin
                  wait_cnt <= wait_cnt + cnt_width'(1);
               end
            end
            S_MIX: begin
               mixed <= swapping ? mix_word : cur_word;
               state <= S_OUT_GAIN;
            end
            S_OUT_GAIN: begin
               out_sample <= saturate(out_prod >>> gain_shift);
               out_valid  <= 1'b1;
               ready      <= 1'b1;
               if (swapping) begin
                  if (fade_k == fade_last) begin
                     current_pipeline <= swap_tgt;
                     swapping         <= 1'b0;
                     fade_k           <= '0;
                  end else begin
                     fade_k <= fade_k + 1'b1;
                  end
               end
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef SEQ_OVERRUN_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_count <= '0;
      end else if (sample_valid && !ready && (overrun_count != 16'hFFFF)) begin
         overrun_count <= overrun_count + 16'd1;
      end
   end
`else
   assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: latency, gain saturation, crossfade, swap filtering,
// timeout and asynchronous reset mid-fade (overrun count checked when SEQ_OVERRUN_COUNT_EN is set).
module tb_pipeline_sequencer;

   logic               clk;
   logic               reset;
   logic signed [15:0] in_sample;
   logic               sample_valid;
   logic               ready;
   logic signed [15:0] out_sample;
   logic               out_valid;
   logic signed [15:0] pipe_in_sample;
   logic               pipeline_tick;
   logic [1:0]         pipe_ready;
   logic [31:0]        pipe_out;
   logic signed [15:0] gain_data;
   logic               set_input_gain;
   logic               set_output_gain;
   logic [0:0]         swap_target;
   logic               swap_req;
   logic               swapping;
   logic [0:0]         current_pipeline;
   logic               timeout_error;
   logic [15:0]        overrun_count;

   int checks = 0;
   int errors = 0;

   pipeline_sequencer #(
      .data_width     (16),
      .n_pipelines    (2),
      .gain_shift     (5),
      .fade_len_log2  (2),
      .timeout_cycles (10)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .in_sample        (in_sample),
      .sample_valid     (sample_valid),
      .ready            (ready),
      .out_sample       (out_sample),
      .out_valid        (out_valid),
      .pipe_in_sample   (pipe_in_sample),
      .pipeline_tick    (pipeline_tick),
      .pipe_ready       (pipe_ready),
      .pipe_out         (pipe_out),
      .gain_data        (gain_data),
      .set_input_gain   (set_input_gain),
      .set_output_gain  (set_output_gain),
      .swap_target      (swap_target),
      .swap_req         (swap_req),
      .swapping         (swapping),
      .current_pipeline (current_pipeline),
      .timeout_error    (timeout_error),
      .overrun_count    (overrun_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // driver tasks
   task automatic set_pipe(input int p0, input int p1);
      pipe_out[15:0]  = p0[15:0];
      pipe_out[31:16] = p1[15:0];
   endtask

   task automatic write_gain(input int value, input logic gin, input logic gout);
      @(negedge clk);
      gain_data       = value[15:0];
      set_input_gain  = gin;
      set_output_gain = gout;
      @(negedge clk);
      set_input_gain  = 1'b0;
      set_output_gain = 1'b0;
   endtask

   task automatic request_swap(input logic [0:0] target);
      @(negedge clk);
      swap_target = target;
      swap_req    = 1'b1;
      @(negedge clk);
      swap_req    = 1'b0;
   endtask

   // Sends one sample, then tracks tick timing, pipe_in_sample and output latency.
   task automatic run_sample(input string tag, input int value, input int exp_lat,
                             input int exp_pis, input int exp_out);
      int   cyc;
      int   tick_cyc;
      logic got;
      @(negedge clk);
      check({tag, "_ready_before"}, ready, 1);
      in_sample    = value[15:0];
      sample_valid = 1'b1;
      cyc      = 0;
      tick_cyc = -1;
      got      = 1'b0;
      while (!got && cyc < 60) begin
         @(negedge clk);
         cyc++;
         sample_valid = 1'b0;
         if (pipeline_tick) begin
            tick_cyc = cyc;
            check({tag, "_pipe_in"}, pipe_in_sample, exp_pis);
         end
         if (out_valid) got = 1'b1;
      end
      check({tag, "_tick_cycle"}, tick_cyc, 2);
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_out"}, out_sample, exp_out);
      check({tag, "_ready_after"}, ready, 1);
   endtask

   initial begin
      int exp_overrun;
`ifdef SEQ_OVERRUN_COUNT_EN
      exp_overrun = 3;
`else
      exp_overrun = 0;
`endif
      reset           = 1'b1;
      in_sample       = '0;
      sample_valid    = 1'b0;
      pipe_ready      = 2'b11;
      pipe_out        = '0;
      gain_data       = '0;
      set_input_gain  = 1'b0;
      set_output_gain = 1'b0;
      swap_target     = '0;
      swap_req        = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_ready", ready, 1);
      check("rst_out_sample", out_sample, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_pipe_in", pipe_in_sample, 0);
      check("rst_tick", pipeline_tick, 0);
      check("rst_swapping", swapping, 0);
      check("rst_current", current_pipeline, 0);
      check("rst_timeout", timeout_error, 0);
      check("rst_overrun", overrun_count, 0);
      reset = 1'b0;

      // unity gains, basic latency
      set_pipe(1000, 0);
      run_sample("basic", 500, 6, 500, 1000);
      @(negedge clk);
      check("basic_valid_one_cycle", out_valid, 0);

      // input gain 2.0 saturates both ways
      write_gain(64, 1'b1, 1'b0);
      run_sample("sat_pos", 20000, 6, 32767, 1000);
      run_sample("sat_neg", -20000, 6, -32768, 1000);

      // output gain 0.5 with arithmetic shift of a negative product
      write_gain(32, 1'b1, 1'b0);
      write_gain(16, 1'b0, 1'b1);
      set_pipe(-3, 0);
      run_sample("out_half", 7, 6, 7, -2);

      // crossfade 0 -> 1 over four samples
      write_gain(32, 1'b1, 1'b1);
      set_pipe(0, 400);
      request_swap(1'b1);
      check("swap_started", swapping, 1);
      run_sample("fade0", 1, 6, 1, 0);
      request_swap(1'b0);
      check("swap_during_fade_kept", swapping, 1);
      run_sample("fade1", 1, 6, 1, 100);
      run_sample("fade2", 1, 6, 1, 200);
      run_sample("fade3", 1, 6, 1, 300);
      check("fade_done_current", current_pipeline, 1);
      check("fade_done_swapping", swapping, 0);
      run_sample("after_fade", 1, 6, 1, 400);
      request_swap(1'b1);
      check("swap_same_ignored", swapping, 0);
      check("swap_same_current", current_pipeline, 1);

      // timeout with no pipeline ready
      pipe_ready = 2'b00;
      run_sample("timeout", 2, 14, 2, 400);
      check("timeout_flag", timeout_error, 1);
      pipe_ready = 2'b11;
      run_sample("post_timeout", 3, 6, 3, 400);
      check("timeout_sticky", timeout_error, 1);

      // both gains written at once, then a fade back to pipeline 0
      write_gain(48, 1'b1, 1'b1);
      set_pipe(0, 400);
      request_swap(1'b0);
      check("swap_back_started", swapping, 1);
      run_sample("gain_both", 100, 6, 150, 600);

      // reset during WAIT of a fade, with overrun pulses while busy
      pipe_ready = 2'b00;
      @(negedge clk);
      in_sample    = 16'sd5;
      sample_valid = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         sample_valid = (c == 1 || c == 3 || c == 5);
      end
      check("busy_ready", ready, 0);
      check("busy_swapping", swapping, 1);
      check("busy_overrun", overrun_count, exp_overrun);
      #1 reset = 1'b1;
      #1;
      check("midrst_ready", ready, 1);
      check("midrst_swapping", swapping, 0);
      check("midrst_current", current_pipeline, 0);
      check("midrst_timeout", timeout_error, 0);
      check("midrst_overrun", overrun_count, 0);
      @(negedge clk);
      reset      = 1'b0;
      pipe_ready = 2'b11;
      set_pipe(-1000, 400);
      run_sample("post_reset_unity", 100, 6, 100, -1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Per-sample scheduler for a multi-pipeline DSP engine, generalised from two pipelines to n_pipelines.
- Per sample: latches the incoming sample, applies saturating input gain, ticks all pipelines and waits (with timeout) for the required ones.
- Crossfades linearly from the current pipeline to a requested target over 2^fade_len_log2 samples, then applies saturating output gain.
- Sits between the codec sample interface, the pipeline array and the control unit.

Parameters:
data_width, 16, sample and gain word width (signed).
n_pipelines, 2, number of DSP pipelines (>=2).
gain_shift, 5, fractional bits of gain words; unity gain = 1<<gain_shift.
fade_len_log2, 8, crossfade length is 2^fade_len_log2 samples.
timeout_cycles, 1023, maximum cycles spent in WAIT before forced mix.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_sample  in  data_width  signed input sample
sample_valid  in  1  one-cycle strobe; accepted only while ready=1
ready  out  1  idle, able to accept a sample
out_sample  out  data_width  signed processed sample
out_valid  out  1  one-cycle strobe, out_sample updated
pipe_in_sample  out  data_width  gained input to all pipelines
pipeline_tick  out  1  one-cycle strobe to all pipelines
pipe_ready  in  n_pipelines  per-pipeline done flags
pipe_out  in  n_pipelines*data_width  pipeline outputs; pipeline i at bits [i*data_width +: data_width]
gain_data  in  data_width  gain value from control unit
set_input_gain  in  1  load gain_data into input gain
set_output_gain  in  1  load gain_data into output gain
swap_target  in  max(1,$clog2(n_pipelines))  requested pipeline
swap_req  in  1  one-cycle crossfade request
swapping  out  1  crossfade in progress
current_pipeline  out  max(1,$clog2(n_pipelines))  active pipeline index
timeout_error  out  1  sticky, WAIT timed out at least once
overrun_count  out  16  dropped-sample counter (see Optional Feature)

Behaviour:
- Reset values (asynchronous, also mid-operation): ready=1, out_sample=0, out_valid=0, pipe_in_sample=0, pipeline_tick=0, swapping=0, current_pipeline=0, timeout_error=0, overrun_count=0, both gains=1<<gain_shift, fade counter k=0, state=IDLE. Any swap in progress is aborted.
- States and transitions:
  - IDLE: ready=1. On sample_valid, latch in_sample, ready<=0, go to IN_GAIN.
  - IN_GAIN: pipe_in_sample<=sat(in*gin>>>gain_shift); pipeline_tick<=1; go to SETTLE.
  - SETTLE: pipe_ready ignored for this one cycle; go to WAIT.
  - WAIT: required set is pipe_ready[current], plus pipe_ready[target] while swapping. When the required set is all 1, go to MIX. When the wait counter reaches timeout_cycles, set timeout_error and go to MIX using pipe_out as presented.
  - MIX: mixed<=(cur*(2^L-k)+tgt*k)>>>L with L=fade_len_log2, evaluated only while swapping; otherwise mixed<=cur. Go to OUT_GAIN.
  - OUT_GAIN: out_sample<=sat(mixed*gout>>>gain_shift); out_valid<=1; ready<=1; update fade; go to IDLE.
- Latency: with pipe_ready held high, sample_valid in cycle 0 gives pipeline_tick high in cycle 2 and out_valid plus ready=1 in cycle 6. Minimum sample period is 6 cycles.
- Arithmetic:
  - Gain product is 2*data_width signed, arithmetic shift, then saturated to [-2^(data_width-1), 2^(data_width-1)-1].
  - Crossfade products are data_width+L+1 bits. The result is a convex combination, so no saturation is applied.
- Fade: k increments once per output sample while swapping. When the increment makes k=2^L: current_pipeline<=target, swapping<=0, k<=0. The last blended sample uses k=2^L-1.
- Swap requests:
  - Accepted in any state when swapping=0 and swap_target!=current_pipeline and swap_target<n_pipelines.
  - Otherwise ignored: dropped while swapping, a no-op for the same target, ignored when out of range.
  - An accepted request sets swapping=1 at the next edge; blending starts with the next MIX.
- Gain writes: take effect at the next edge. A write in the same cycle as IN_GAIN/OUT_GAIN does not affect that computation. If set_input_gain and set_output_gain are asserted together, both gains load.
- sample_valid while ready=0 is dropped.

Optional Feature:
SEQ_OVERRUN_COUNT_EN:
- Defined: overrun_count increments, saturating at 16'hFFFF, on every sample_valid with ready=0.
- Undefined: overrun_count is tied to 0 and no counter logic is built.

Test Plan:
- Unity gains, n_pipelines=2, pipe_ready=2'b11, pipe_out[0]=1000, sample 500 -> pipe_in_sample=500 with tick in cycle 2; out_sample=1000, out_valid in cycle 6.
- Input gain 64 (2.0), sample 20000 -> pipe_in_sample saturates to 32767. Output gain 16 (0.5), pipe_out[0]=-3 -> out_sample=-2 (arithmetic shift).
- fade_len_log2=2, pipe_out[0]=0, pipe_out[1]=400, swap_req target 1 -> successive outputs 0,100,200,300; then current_pipeline=1, swapping=0, output 400.
- swap_req during a fade, and swap_req to the current pipeline -> both ignored; current_pipeline follows only the first request.
- timeout_cycles=10, pipe_ready held 0 -> timeout_error=1 and out_valid 14 cycles after sample_valid; error stays set through later samples.
- Reset asserted mid-fade during WAIT -> immediately ready=1, swapping=0, current_pipeline=0, gains unity. With SEQ_OVERRUN_COUNT_EN, 3 sample_valid pulses while busy give overrun_count=3 before the reset.
